// File: rtl/me_pkg.sv
// Shared constants, types and helpers for the SAD motion-estimation core.
//   PIX_W     : pixel width in bits
//   BLK       : current block edge (16x16 pixels)
//   WIN       : search-window edge (23x23 pixels)
//   NCAND     : candidate offsets per axis (8x8 positions)
//   SAD_W     : accumulated SAD width
//   ROW_SAD_W : width of one 16-pixel row SAD (16*255 = 4080)
package me_pkg;

    localparam int PIX_W     = 8;
    localparam int BLK       = 16;
    localparam int WIN       = 23;
    localparam int NCAND     = 8;
    localparam int SAD_W     = 16;
    localparam int ROW_SAD_W = 12;

    typedef logic [BLK*PIX_W-1:0] pix_row_t;
    typedef logic [SAD_W-1:0]     sad_t;
    typedef sad_t                 sad_arr_t [NCAND][NCAND];

    // Absolute difference of two unsigned pixels through a 9-bit signed difference.
    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
        logic signed [PIX_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        if (d[PIX_W]) begin
            abs_diff = PIX_W'(-d);
        end else begin
            abs_diff = d[PIX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/sad16_row.sv
// Combinational SAD of one 16-pixel row: per-pixel absolute difference
// followed by a balanced four-level adder tree.
//   ref_pix : 16 reference pixels, pixel k at [8k+7:8k]
//   cur_pix : 16 current-block pixels, same packing
//   sad     : sum of |ref - cur| over the 16 pixels
module sad16_row
    import me_pkg::*;
(
    input  pix_row_t               ref_pix,
    input  pix_row_t               cur_pix,
    output logic [ROW_SAD_W-1:0]   sad
);

    logic [PIX_W-1:0] diff_s [BLK];
    logic [PIX_W:0]   lvl1_s [8];
    logic [PIX_W+1:0] lvl2_s [4];
    logic [PIX_W+2:0] lvl3_s [2];

    // Per-pixel absolute differences and the adder tree, each level one bit wider.
    always_comb begin
        for (int k = 0; k < BLK; k++) begin
            diff_s[k] = abs_diff(ref_pix[k*PIX_W +: PIX_W], cur_pix[k*PIX_W +: PIX_W]);
        end
        for (int i = 0; i < 8; i++) begin
            lvl1_s[i] = {1'b0, diff_s[2*i]} + {1'b0, diff_s[2*i+1]};
        end
        for (int i = 0; i < 4; i++) begin
            lvl2_s[i] = {1'b0, lvl1_s[2*i]} + {1'b0, lvl1_s[2*i+1]};
        end
        for (int i = 0; i < 2; i++) begin
            lvl3_s[i] = {1'b0, lvl2_s[2*i]} + {1'b0, lvl2_s[2*i+1]};
        end
        sad = {1'b0, lvl3_s[0]} + {1'b0, lvl3_s[1]};
    end

endmodule

// File: rtl/sad_search_engine.sv
// Full-search motion estimation: 16x16 current block against a 23x23 window,
// 8x8 candidate offsets, best vector and its SAD reported after a two-stage compare.
//   clk, reset (async, active-low)
//   frame_end : synchronous clear of counters, bank flags, pointers and err
//   ref_en / ref_row   : one window row per accepted pulse (23 pixels)
//   cur_load / cur_row : one current-block row per accepted pulse (16 pixels)
//   cur_ready : registered, the write bank has room
//   mv_valid  : one-cycle result pulse; mv_x/mv_y/min_sad hold until the next one
//   err       : sticky, a row was dropped
module sad_search_engine
    import me_pkg::*;
#(
    parameter int PIX_W = me_pkg::PIX_W,
    parameter int SAD_W = me_pkg::SAD_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_end,
    input  logic                 ref_en,
    input  logic [WIN*PIX_W-1:0] ref_row,
    input  logic                 cur_load,
    input  logic [BLK*PIX_W-1:0] cur_row,
    output logic                 cur_ready,
    output logic                 mv_valid,
    output logic [2:0]           mv_x,
    output logic [2:0]           mv_y,
    output logic [SAD_W-1:0]     min_sad,
    output logic                 err
);

    logic [1:0] full_r;
    logic       wr_r;
    logic       rd_r;
    logic [3:0] cur_cnt_r;
    logic [4:0] ref_cnt_r;
    logic       err_r;
    logic       cur_ready_r;

    logic       cur_acc_s;
    logic       ref_acc_s;
    logic       cur_last_s;
    logic       ref_last_s;
    logic       drop_s;
    logic [1:0] full_nxt_s;
    logic       wr_nxt_s;
    logic       rd_nxt_s;

    pix_row_t   bank_r [2][BLK];
    sad_arr_t   acc_r;

    logic [4:0]           idx_s       [NCAND];
    logic                 row_use_s   [NCAND];
    logic                 row_first_s [NCAND];
    pix_row_t             row_sel_s   [NCAND];
    logic [ROW_SAD_W-1:0] row_sad_s   [NCAND][NCAND];

    sad_t       c1_best_s [NCAND];
    logic [2:0] c1_h_s    [NCAND];
    sad_t       c1_sad_r  [NCAND];
    logic [2:0] c1_h_r    [NCAND];
    logic       cmp_start_r;
    logic       c1_valid_r;

    sad_t       c2_sad_s;
    logic [2:0] c2_h_s;
    logic [2:0] c2_v_s;

    logic             mv_valid_r;
    logic [2:0]       mv_x_r;
    logic [2:0]       mv_y_r;
    logic [SAD_W-1:0] min_sad_r;

    // Accept/drop decisions and next bank flags. A completing load and a
    // completing search can never target the same bank: loading needs the
    // write bank empty, searching needs the read bank full.
    always_comb begin
        cur_acc_s  = cur_load && cur_ready_r;
        ref_acc_s  = ref_en && full_r[rd_r];
        cur_last_s = cur_acc_s && (cur_cnt_r == 4'd15);
        ref_last_s = ref_acc_s && (ref_cnt_r == 5'd22);
        drop_s     = (cur_load && !cur_ready_r) || (ref_en && !full_r[rd_r]);
        full_nxt_s       = full_r;
        full_nxt_s[wr_r] = full_r[wr_r] | cur_last_s;
        full_nxt_s[rd_r] = full_nxt_s[rd_r] & ~ref_last_s;
        wr_nxt_s   = cur_last_s ? ~wr_r : wr_r;
        rd_nxt_s   = ref_last_s ? ~rd_r : rd_r;
    end

    // Bank flags, pointers, row counters, sticky error and registered ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_r      <= 2'b00;
            wr_r        <= 1'b0;
            rd_r        <= 1'b0;
            cur_cnt_r   <= 4'd0;
            ref_cnt_r   <= 5'd0;
            err_r       <= 1'b0;
            cur_ready_r <= 1'b0;
        end else if (frame_end) begin
            full_r      <= 2'b00;
            wr_r        <= 1'b0;
            rd_r        <= 1'b0;
            cur_cnt_r   <= 4'd0;
            ref_cnt_r   <= 5'd0;
            err_r       <= 1'b0;
            cur_ready_r <= 1'b1;
        end else begin
            full_r      <= full_nxt_s;
            wr_r        <= wr_nxt_s;
            rd_r        <= rd_nxt_s;
            if (cur_acc_s) begin
                cur_cnt_r <= cur_cnt_r + 4'd1;   // 15 wraps to 0
            end
            if (ref_last_s) begin
                ref_cnt_r <= 5'd0;
            end else if (ref_acc_s) begin
                ref_cnt_r <= ref_cnt_r + 5'd1;
            end
            err_r       <= err_r | drop_s;
            cur_ready_r <= ~full_nxt_s[wr_nxt_s];
        end
    end

    // Current-block bank storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (cur_acc_s && !frame_end) begin
            bank_r[rd_r ^ rd_r ^ wr_r][cur_cnt_r] <= cur_row;
        end
    end

    // For vertical offset v, window row r pairs with current row r-v when 0 <= r-v <= 15.
    always_comb begin
        for (int v = 0; v < NCAND; v++) begin
            idx_s[v]       = ref_cnt_r - 5'(v);
            row_use_s[v]   = (ref_cnt_r >= 5'(v)) && (idx_s[v] <= 5'd15);
            row_first_s[v] = (ref_cnt_r == 5'(v));
            row_sel_s[v]   = bank_r[rd_r][idx_s[v][3:0]];
        end
    end

    for (genvar gv = 0; gv < NCAND; gv++) begin : g_v
        for (genvar gh = 0; gh < NCAND; gh++) begin : g_h
            sad16_row u_row (
                .ref_pix (ref_row[gh*PIX_W +: BLK*PIX_W]),
                .cur_pix (row_sel_s[gv]),
                .sad     (row_sad_s[gv][gh])
            );
        end
    end

    // Candidate accumulators: the first contributing row loads, later rows add,
    // so a new block (or a block after reset) never sees stale sums.
    always_ff @(posedge clk) begin
        if (ref_acc_s && !frame_end) begin
            for (int v = 0; v < NCAND; v++) begin
                for (int h = 0; h < NCAND; h++) begin
                    if (row_first_s[v]) begin
                        acc_r[v][h] <= sad_t'(row_sad_s[v][h]);
                    end else if (row_use_s[v]) begin
                        acc_r[v][h] <= acc_r[v][h] + sad_t'(row_sad_s[v][h]);
                    end
                end
            end
        end
    end

    // Stage-1 compare: minimum over h per row v; strict less-than keeps the lowest h.
    always_comb begin
        for (int v = 0; v < NCAND; v++) begin
            c1_best_s[v] = acc_r[v][0];
            c1_h_s[v]    = 3'd0;
            for (int h = 1; h < NCAND; h++) begin
                if (acc_r[v][h] < c1_best_s[v]) begin
                    c1_best_s[v] = acc_r[v][h];
                    c1_h_s[v]    = 3'(h);
                end else begin
                    c1_best_s[v] = c1_best_s[v];
                    c1_h_s[v]    = c1_h_s[v];
                end
            end
        end
    end

    // Stage-1 registers; frame_end deliberately does not cancel a compare in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmp_start_r <= 1'b0;
            c1_valid_r  <= 1'b0;
            for (int v = 0; v < NCAND; v++) begin
                c1_sad_r[v] <= '0;
                c1_h_r[v]   <= 3'd0;
            end
        end else begin
            cmp_start_r <= ref_last_s && !frame_end;
            c1_valid_r  <= cmp_start_r;
            if (cmp_start_r) begin
                for (int v = 0; v < NCAND; v++) begin
                    c1_sad_r[v] <= c1_best_s[v];
                    c1_h_r[v]   <= c1_h_s[v];
                end
            end
        end
    end

    // Stage-2 compare: minimum over v; lower v wins ties, giving lowest scan index overall.
    always_comb begin
        c2_sad_s = c1_sad_r[0];
        c2_h_s   = c1_h_r[0];
        c2_v_s   = 3'd0;
        for (int v = 1; v < NCAND; v++) begin
            if (c1_sad_r[v] < c2_sad_s) begin
                c2_sad_s = c1_sad_r[v];
                c2_h_s   = c1_h_r[v];
                c2_v_s   = 3'(v);
            end else begin
                c2_sad_s = c2_sad_s;
                c2_h_s   = c2_h_s;
                c2_v_s   = c2_v_s;
            end
        end
    end

    // Result registers; values hold between pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mv_valid_r <= 1'b0;
            mv_x_r     <= 3'd0;
            mv_y_r     <= 3'd0;
            min_sad_r  <= '0;
        end else begin
            mv_valid_r <= c1_valid_r;
            if (c1_valid_r) begin
                mv_x_r    <= c2_h_s;
                mv_y_r    <= c2_v_s;
                min_sad_r <= SAD_W'(c2_sad_s);
            end
        end
    end

    assign cur_ready = cur_ready_r;
    assign err       = err_r;
    assign mv_valid  = mv_valid_r;
    assign mv_x      = mv_x_r;
    assign mv_y      = mv_y_r;
    assign min_sad   = min_sad_r;

endmodule

// File: tb/tb_sad_search_engine.sv
// Self-checking bench for sad_search_engine. A brute-force full-search model
// (direct SAD definition over all 64 offsets) supplies expected vectors.
module tb_sad_search_engine;

    logic         clk = 1'b0;
    logic         reset;
    logic         frame_end;
    logic         ref_en;
    logic [183:0] ref_row;
    logic         cur_load;
    logic [127:0] cur_row;
    logic         cur_ready;
    logic         mv_valid;
    logic [2:0]   mv_x;
    logic [2:0]   mv_y;
    logic [15:0]  min_sad;
    logic         err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int cur_a [2][16][16];
    int win_a [2][23][23];

    typedef struct {
        int x;
        int y;
        int sad;
        int c;
    } mv_t;
    mv_t mv_q [$];

    sad_search_engine dut (
        .clk       (clk),
        .reset     (reset),
        .frame_end (frame_end),
        .ref_en    (ref_en),
        .ref_row   (ref_row),
        .cur_load  (cur_load),
        .cur_row   (cur_row),
        .cur_ready (cur_ready),
        .mv_valid  (mv_valid),
        .mv_x      (mv_x),
        .mv_y      (mv_y),
        .min_sad   (min_sad),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mv_valid === 1'b1) begin
            mv_q.push_back('{int'(mv_x), int'(mv_y), int'(min_sad), cyc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_frame_end();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic rand_fill(input int s);
        for (int r = 0; r < 16; r++)
            for (int k = 0; k < 16; k++)
                cur_a[s][r][k] = int'($urandom_range(255, 0));
        for (int r = 0; r < 23; r++)
            for (int c = 0; c < 23; c++)
                win_a[s][r][c] = int'($urandom_range(255, 0));
    endtask

    task automatic load_block(input int s);
        for (int r = 0; r < 16; r++) begin
            for (int k = 0; k < 16; k++) cur_row[k*8 +: 8] = 8'(cur_a[s][r][k]);
            cur_load = 1'b1;
            tick();
        end
        cur_load = 1'b0;
    endtask

    task automatic send_window(input int s, input int nrows, input int tail, output int acc_cyc);
        acc_cyc = -1;
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < 23; c++) ref_row[c*8 +: 8] = 8'(win_a[s][r][c]);
            ref_en = 1'b1;
            tick();
            if (r == 22) acc_cyc = cyc;
        end
        ref_en = 1'b0;
        repeat (tail) tick();
    endtask

    // Brute force: lowest SAD, first found in v-major/h-minor scan order.
    function automatic void model(input int s, output int bx, output int by, output int bs);
        bs = 32'h7fffffff;
        bx = 0;
        by = 0;
        for (int v = 0; v < 8; v++) begin
            for (int h = 0; h < 8; h++) begin
                int sum = 0;
                for (int r = 0; r < 16; r++)
                    for (int k = 0; k < 16; k++) begin
                        int d = win_a[s][v+r][h+k] - cur_a[s][r][k];
                        sum += (d < 0) ? -d : d;
                    end
                if (sum < bs) begin
                    bs = sum;
                    bx = h;
                    by = v;
                end
            end
        end
    endfunction

    task automatic get_mv(output mv_t m);
        if (mv_q.size() > 0) m = mv_q.pop_front();
        else m = '{-1, -1, -1, -1};
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({cur_ready, mv_valid, mv_x, mv_y, min_sad, err} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {cur_ready, mv_valid, mv_x, mv_y, min_sad, err});
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++;
        if (cur_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cur_ready: got %b expected 1", cur_ready);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %b expected 0", err);
        end
    endtask

    task automatic test_exact_match();
        int acc;
        mv_t m;
        do_frame_end();
        mv_q.delete();
        rand_fill(0);
        for (int r = 0; r < 16; r++)
            for (int k = 0; k < 16; k++) cur_a[0][r][k] = win_a[0][2+r][5+k];
        load_block(0);
        send_window(0, 23, 0, acc);
        repeat (4) tick();
        get_mv(m);
        checks++;
        if (m.x !== 5 || m.y !== 2 || m.sad !== 0) begin
            errors++;
            $display("FAIL exact_vec: got x=%0d y=%0d sad=%0d expected x=5 y=2 sad=0", m.x, m.y, m.sad);
        end
        checks++;
        if (m.c !== acc + 2) begin
            errors++;
            $display("FAIL exact_latency: got cycle %0d expected %0d", m.c, acc + 2);
        end
        checks++;
        if (mv_q.size() != 0) begin
            errors++;
            $display("FAIL exact_pulse_width: got %0d extra pulses expected 0", mv_q.size());
        end
        repeat (3) tick();
        checks++;
        if (mv_x !== 3'd5 || mv_y !== 3'd2 || min_sad !== 16'd0) begin
            errors++;
            $display("FAIL exact_hold: got x=%0d y=%0d sad=%0d expected 5 2 0", mv_x, mv_y, min_sad);
        end
    endtask

    task automatic test_worst_case();
        int acc;
        mv_t m;
        do_frame_end();
        mv_q.delete();
        for (int r = 0; r < 16; r++)
            for (int k = 0; k < 16; k++) cur_a[0][r][k] = 0;
        for (int r = 0; r < 23; r++)
            for (int c = 0; c < 23; c++) win_a[0][r][c] = 255;
        load_block(0);
        send_window(0, 23, 0, acc);
        repeat (4) tick();
        get_mv(m);
        checks++;
        if (m.x !== 0 || m.y !== 0 || m.sad !== 65280) begin
            errors++;
            $display("FAIL worst_vec: got x=%0d y=%0d sad=%0d expected x=0 y=0 sad=65280", m.x, m.y, m.sad);
        end
    endtask

    task automatic test_tie();
        int acc;
        int p [16][3];
        mv_t m;
        do_frame_end();
        mv_q.delete();
        rand_fill(0);
        for (int r = 0; r < 16; r++)
            for (int j = 0; j < 3; j++) p[r][j] = int'($urandom_range(255, 0));
        for (int r = 0; r < 16; r++) begin
            for (int k = 0; k < 16; k++) cur_a[0][r][k] = p[r][k % 3];
            for (int c = 3; c < 22; c++) win_a[0][1+r][c] = p[r][(c - 3) % 3];
        end
        load_block(0);
        send_window(0, 23, 0, acc);
        repeat (4) tick();
        get_mv(m);
        checks++;
        if (m.x !== 3 || m.y !== 1 || m.sad !== 0) begin
            errors++;
            $display("FAIL tie_vec: got x=%0d y=%0d sad=%0d expected x=3 y=1 sad=0", m.x, m.y, m.sad);
        end
    endtask

    task automatic test_underflow();
        int acc;
        int ex, ey, es;
        mv_t m;
        do_frame_end();
        mv_q.delete();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL underflow_err_before: got %b expected 0", err);
        end
        rand_fill(0);
        send_window(0, 1, 0, acc);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL underflow_err_set: got %b expected 1", err);
        end
        repeat (5) tick();
        checks++;
        if (mv_q.size() != 0) begin
            errors++;
            $display("FAIL underflow_no_pulse: got %0d pulses expected 0", mv_q.size());
        end
        rand_fill(1);
        load_block(1);
        send_window(1, 23, 0, acc);
        repeat (4) tick();
        get_mv(m);
        model(1, ex, ey, es);
        checks++;
        if (m.x !== ex || m.y !== ey || m.sad !== es || m.c !== acc + 2) begin
            errors++;
            $display("FAIL underflow_recover: got x=%0d y=%0d sad=%0d c=%0d expected x=%0d y=%0d sad=%0d c=%0d",
                     m.x, m.y, m.sad, m.c, ex, ey, es, acc + 2);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL underflow_err_sticky: got %b expected 1", err);
        end
        do_frame_end();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL frame_end_clears_err: got %b expected 0", err);
        end
    endtask

    task automatic test_back_to_back();
        int acc_a, acc_b, a0, a1;
        int ex0, ey0, es0, ex1, ey1, es1;
        mv_t ma, mb;
        do_frame_end();
        mv_q.delete();
        rand_fill(0);
        rand_fill(1);
        load_block(0);
        fork
            begin
                send_window(0, 23, 3, acc_a);
                send_window(1, 23, 3, acc_b);
            end
            begin
                repeat (5) tick();
                load_block(1);
            end
        join
        repeat (4) tick();
        get_mv(ma);
        get_mv(mb);
        model(0, ex0, ey0, es0);
        model(1, ex1, ey1, es1);
        checks++;
        if (ma.x !== ex0 || ma.y !== ey0 || ma.sad !== es0 || ma.c !== acc_a + 2) begin
            errors++;
            $display("FAIL b2b_first: got x=%0d y=%0d sad=%0d c=%0d expected x=%0d y=%0d sad=%0d c=%0d",
                     ma.x, ma.y, ma.sad, ma.c, ex0, ey0, es0, acc_a + 2);
        end
        checks++;
        if (mb.x !== ex1 || mb.y !== ey1 || mb.sad !== es1) begin
            errors++;
            $display("FAIL b2b_second: got x=%0d y=%0d sad=%0d expected x=%0d y=%0d sad=%0d",
                     mb.x, mb.y, mb.sad, ex1, ey1, es1);
        end
        checks++;
        if (mb.c - ma.c !== 26) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles expected 26", mb.c - ma.c);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_drop: got err=%b expected 0", err);
        end
        rand_fill(0);
        rand_fill(1);
        load_block(0);
        load_block(1);
        checks++;
        if (cur_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_cur_ready: got %b expected 0", cur_ready);
        end
        cur_load = 1'b1;
        tick();
        cur_load = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL overflow_err: got %b expected 1", err);
        end
        send_window(0, 23, 0, a0);
        send_window(1, 23, 0, a1);
        repeat (4) tick();
        get_mv(ma);
        get_mv(mb);
        model(0, ex0, ey0, es0);
        model(1, ex1, ey1, es1);
        checks++;
        if (ma.x !== ex0 || ma.y !== ey0 || ma.sad !== es0 || mb.x !== ex1 || mb.y !== ey1 || mb.sad !== es1) begin
            errors++;
            $display("FAIL overflow_drain: got %0d/%0d/%0d %0d/%0d/%0d expected %0d/%0d/%0d %0d/%0d/%0d",
                     ma.x, ma.y, ma.sad, mb.x, mb.y, mb.sad, ex0, ey0, es0, ex1, ey1, es1);
        end
    endtask

    task automatic test_reset_mid_block();
        int acc;
        int ex, ey, es;
        mv_t m;
        do_frame_end();
        rand_fill(0);
        load_block(0);
        send_window(0, 11, 0, acc);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({cur_ready, mv_valid, mv_x, mv_y, min_sad, err} !== 25'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h expected 0", {cur_ready, mv_valid, mv_x, mv_y, min_sad, err});
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        mv_q.delete();
        rand_fill(0);
        load_block(0);
        send_window(0, 23, 0, acc);
        repeat (4) tick();
        get_mv(m);
        model(0, ex, ey, es);
        checks++;
        if (m.x !== ex || m.y !== ey || m.sad !== es || m.c !== acc + 2) begin
            errors++;
            $display("FAIL midreset_result: got x=%0d y=%0d sad=%0d c=%0d expected x=%0d y=%0d sad=%0d c=%0d",
                     m.x, m.y, m.sad, m.c, ex, ey, es, acc + 2);
        end
    endtask

    initial begin
        reset     = 1'b0;
        frame_end = 1'b0;
        ref_en    = 1'b0;
        ref_row   = '0;
        cur_load  = 1'b0;
        cur_row   = '0;
        test_reset();
        test_exact_match();
        test_worst_case();
        test_tie();
        test_underflow();
        test_back_to_back();
        test_reset_mid_block();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
